// File: rtl/audio_eth_pkg.sv
// rtl/audio_eth_pkg.sv - shared constants and FSM encoding for the audio UDP packer
// Purpose: default packet geometry, sync word and the packer state encoding.
// Ports: none (package).
package audio_eth_pkg;

  localparam int          DEF_SAMPLES_PER_PKT = 255;
  localparam logic [15:0] DEF_SYNC_WORD       = 16'hA55A;
  localparam int          DEF_SFIFO_AW        = 4;
  localparam int          HDR_LEN             = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_SMP  = 2'd2
  } pkt_state_t;

endpackage

// File: rtl/audio_sample_fifo.sv
// rtl/audio_sample_fifo.sv - synchronous stereo sample FIFO
// Purpose: buffers {L,R} sample words between capture and byte emission.
// Ports: clk/rst (sync, active-high); wr_en/wr_data push side;
//        rd_en pop strobe, rd_data head word (show-ahead), full/empty flags.
module audio_sample_fifo #(
  parameter int AW = 4,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_wr, do_rd;

  // A pushed word becomes visible on rd_data one cycle after the push,
  // once count_q has moved off zero.
  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    do_rd    = rd_en && !empty;
    // A pop in the same cycle frees a slot, so a push at full is accepted.
    do_wr    = wr_en && (!full || do_rd);
    wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (do_wr && !do_rd) begin
      count_d = count_q + 1'b1;
    end else if (do_rd && !do_wr) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/audio_udp_packer.sv
// rtl/audio_udp_packer.sv - frames stereo audio samples into fixed UDP payload byte stream
// Purpose: header (sync word + sequence) followed by SAMPLES_PER_PKT big-endian L/R samples.
// Ports: sys_clk, rst (sync, active-high); sample_valid/ldata_in/rdata_in capture;
//        tx_almost_full back-pressure; tx_wr_en/tx_wr_data byte write port;
//        pkt_seq current/last packet number; overflow sticky drop flag; drop_cnt saturating.
module audio_udp_packer
  import audio_eth_pkg::*;
#(
  parameter int          SAMPLES_PER_PKT = DEF_SAMPLES_PER_PKT,
  parameter logic [15:0] SYNC_WORD       = DEF_SYNC_WORD,
  parameter int          SFIFO_AW        = DEF_SFIFO_AW
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        sample_valid,
  input  logic [15:0] ldata_in,
  input  logic [15:0] rdata_in,
  input  logic        tx_almost_full,
  output logic        tx_wr_en,
  output logic [7:0]  tx_wr_data,
  output logic [15:0] pkt_seq,
  output logic        overflow,
  output logic [15:0] drop_cnt
);

  localparam logic [15:0] LAST_SMP  = 16'(SAMPLES_PER_PKT - 1);
  localparam logic [1:0]  LAST_BYTE = 2'(HDR_LEN - 1);

  pkt_state_t  state_q, state_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [15:0] smp_cnt_q, smp_cnt_d;
  logic [15:0] pkt_seq_q, pkt_seq_d;
  logic [23:0] smp_q, smp_d;
  logic        tx_wr_en_q, tx_wr_en_d;
  logic [7:0]  tx_wr_data_q, tx_wr_data_d;
  logic        overflow_q, overflow_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  logic        fifo_rd, fifo_full, fifo_empty, drop;
  logic [31:0] fifo_rdata;

  audio_sample_fifo #(.AW(SFIFO_AW), .DW(32)) u_fifo (
    .clk     (sys_clk),
    .rst     (rst),
    .wr_en   (sample_valid),
    .wr_data ({ldata_in, rdata_in}),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign drop       = sample_valid && fifo_full && !fifo_rd;
  assign tx_wr_en   = tx_wr_en_q;
  assign tx_wr_data = tx_wr_data_q;
  assign pkt_seq    = pkt_seq_q;
  assign overflow   = overflow_q;
  assign drop_cnt   = drop_cnt_q;

  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    smp_cnt_d    = smp_cnt_q;
    pkt_seq_d    = pkt_seq_q;
    smp_d        = smp_q;
    tx_wr_en_d   = 1'b0;
    tx_wr_data_d = tx_wr_data_q;
    fifo_rd      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d    = ST_HDR;
          byte_idx_d = 2'd0;
          // Emitting the first sync byte straight from IDLE keeps the
          // sample-to-first-byte latency at two cycles.
          if (!tx_almost_full) begin
            tx_wr_en_d   = 1'b1;
            tx_wr_data_d = SYNC_WORD[15:8];
            byte_idx_d   = 2'd1;
          end
        end
      end
      ST_HDR: begin
        if (!tx_almost_full) begin
          tx_wr_en_d = 1'b1;
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0:    tx_wr_data_d = SYNC_WORD[15:8];
            2'd1:    tx_wr_data_d = SYNC_WORD[7:0];
            2'd2:    tx_wr_data_d = pkt_seq_q[15:8];
            default: tx_wr_data_d = pkt_seq_q[7:0];
          endcase
          if (byte_idx_q == LAST_BYTE) begin
            state_d   = ST_SMP;
            smp_cnt_d = '0;
          end
        end
      end
      ST_SMP: begin
        if (!tx_almost_full && (byte_idx_q != 2'd0 || !fifo_empty)) begin
          tx_wr_en_d = 1'b1;
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0: begin
              // Head word is already on rd_data; first byte comes from it
              // directly, the rest is held until the sample is finished.
              fifo_rd      = 1'b1;
              smp_d        = fifo_rdata[23:0];
              tx_wr_data_d = fifo_rdata[31:24];
            end
            2'd1:    tx_wr_data_d = smp_q[23:16];
            2'd2:    tx_wr_data_d = smp_q[15:8];
            default: tx_wr_data_d = smp_q[7:0];
          endcase
          if (byte_idx_q == LAST_BYTE) begin
            if (smp_cnt_q == LAST_SMP) begin
              state_d   = ST_IDLE;
              pkt_seq_d = pkt_seq_q + 16'd1;
            end else begin
              smp_cnt_d = smp_cnt_q + 16'd1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    overflow_d = overflow_q | drop;
    drop_cnt_d = drop_cnt_q;
    if (drop && drop_cnt_q != 16'hFFFF) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      byte_idx_q   <= '0;
      smp_cnt_q    <= '0;
      pkt_seq_q    <= '0;
      smp_q        <= '0;
      tx_wr_en_q   <= 1'b0;
      tx_wr_data_q <= '0;
      overflow_q   <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      smp_cnt_q    <= smp_cnt_d;
      pkt_seq_q    <= pkt_seq_d;
      smp_q        <= smp_d;
      tx_wr_en_q   <= tx_wr_en_d;
      tx_wr_data_q <= tx_wr_data_d;
      overflow_q   <= overflow_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_audio_udp_packer.sv
// tb/tb_audio_udp_packer.sv - self-checking bench for audio_udp_packer
module tb_audio_udp_packer;

  logic        sys_clk = 1'b0;
  logic        rst;
  logic        sample_valid;
  logic [15:0] ldata_in, rdata_in;
  logic        tx_almost_full;
  logic        tx_wr_en;
  logic [7:0]  tx_wr_data;
  logic [15:0] pkt_seq;
  logic        overflow;
  logic [15:0] drop_cnt;

  always #10 sys_clk = ~sys_clk;

  audio_udp_packer dut (
    .sys_clk        (sys_clk),
    .rst            (rst),
    .sample_valid   (sample_valid),
    .ldata_in       (ldata_in),
    .rdata_in       (rdata_in),
    .tx_almost_full (tx_almost_full),
    .tx_wr_en       (tx_wr_en),
    .tx_wr_data     (tx_wr_data),
    .pkt_seq        (pkt_seq),
    .overflow       (overflow),
    .drop_cnt       (drop_cnt)
  );

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic [31:0] exp_word;
  } vec_t;

  vec_t       vecs [10];
  logic [7:0] got_q [$];
  logic [7:0] exp_q [$];
  int         errors = 0;
  int         checks = 0;

  // Byte collector, sampled just after the active edge.
  always @(posedge sys_clk) begin
    #1;
    if (tx_wr_en === 1'b1) got_q.push_back(tx_wr_data);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_stream(input string name);
    int first_bad = -1;
    checks++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (first_bad < 0 && got_q[i] !== exp_q[i]) first_bad = i;
    if (got_q.size() != exp_q.size() || first_bad >= 0) begin
      errors++;
      if (first_bad >= 0)
        $display("FAIL %s: %0d bytes (expected %0d), byte %0d got %0h expected %0h",
                 name, got_q.size(), exp_q.size(), first_bad, got_q[first_bad], exp_q[first_bad]);
      else
        $display("FAIL %s: %0d bytes, expected %0d", name, got_q.size(), exp_q.size());
    end
  endtask

  task automatic push_hdr(input logic [15:0] seq);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back(seq[15:8]);
    exp_q.push_back(seq[7:0]);
  endtask

  task automatic push_word(input logic [31:0] w);
    exp_q.push_back(w[31:24]);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  // Call just after a negedge; the sample is captured at the next posedge.
  task automatic send(input logic [15:0] l, input logic [15:0] r);
    sample_valid = 1'b1;
    ldata_in     = l;
    rdata_in     = r;
    @(negedge sys_clk);
    sample_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic clear_q();
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic send_ramp510();
    logic [15:0] v;
    for (int i = 0; i < 510; i++) begin
      v = 16'(i);
      send(v, ~v);
      tick(7);
    end
    tick(40);
  endtask

  task automatic exp_ramp510(input logic [15:0] seq0);
    logic [15:0] v;
    for (int i = 0; i < 510; i++) begin
      if (i == 0)   push_hdr(seq0);
      if (i == 255) push_hdr(seq0 + 16'd1);
      v = 16'(i);
      push_word({v, ~v});
    end
  endtask

  initial begin
    int          n;
    int          snap;
    logic [31:0] hdr2;

    vecs[0] = '{16'h0001, 16'hFFFF, 32'h0001FFFF};
    vecs[1] = '{16'h8000, 16'h7FFF, 32'h80007FFF};
    vecs[2] = '{16'hDEAD, 16'hBEEF, 32'hDEADBEEF};
    vecs[3] = '{16'h0000, 16'h0000, 32'h00000000};
    vecs[4] = '{16'hFFFF, 16'h0000, 32'hFFFF0000};
    vecs[5] = '{16'h1357, 16'h2468, 32'h13572468};
    vecs[6] = '{16'hA5A5, 16'h5A5A, 32'hA5A55A5A};
    vecs[7] = '{16'h00FF, 16'hFF00, 32'h00FFFF00};
    vecs[8] = '{16'h7FFF, 16'h8000, 32'h7FFF8000};
    vecs[9] = '{16'hCAFE, 16'hF00D, 32'hCAFEF00D};

    rst = 1'b1; sample_valid = 1'b0; ldata_in = '0; rdata_in = '0; tx_almost_full = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("reset_wr_en", {31'd0, tx_wr_en}, 32'd0);
    chk("reset_wr_data", {24'd0, tx_wr_data}, 32'd0);
    chk("reset_pkt_seq", {16'd0, pkt_seq}, 32'd0);
    chk("reset_overflow", {31'd0, overflow}, 32'd0);
    chk("reset_drop_cnt", {16'd0, drop_cnt}, 32'd0);

    // One packet of a constant sample; first byte latency.
    clear_q();
    send(16'h1234, 16'hABCD);
    chk("latency_cycle1_wr_en", {31'd0, tx_wr_en}, 32'd0);
    tick(1);
    chk("latency_cycle2_wr_en", {31'd0, tx_wr_en}, 32'd1);
    chk("latency_cycle2_data", {24'd0, tx_wr_data}, 32'hA5);
    tick(6);
    for (int i = 1; i < 255; i++) begin
      send(16'h1234, 16'hABCD);
      tick(7);
    end
    tick(40);
    push_hdr(16'h0000);
    for (int i = 0; i < 255; i++) push_word(32'h1234ABCD);
    chk_stream("pkt0_stream");
    chk("pkt0_seq_after", {16'd0, pkt_seq}, 32'd1);

    // Two packets of a ramp after a fresh reset.
    do_reset();
    chk("ramp_seq_after_reset", {16'd0, pkt_seq}, 32'd0);
    clear_q();
    send_ramp510();
    exp_ramp510(16'h0000);
    chk_stream("ramp_two_pkts");
    hdr2 = (got_q.size() >= 1028) ? {got_q[1024], got_q[1025], got_q[1026], got_q[1027]} : 32'hxxxxxxxx;
    chk("ramp_second_header", hdr2, 32'hA55A0001);
    chk("ramp_seq_after", {16'd0, pkt_seq}, 32'd2);

    // Back-pressure held mid-sample while samples keep arriving.
    clear_q();
    send(vecs[0].l, vecs[0].r);
    n = 0;
    while (got_q.size() < 6 && n < 50) begin
      tick(1);
      n++;
    end
    chk("bp_reached_mid_sample", {31'd0, n < 50}, 32'd1);
    tx_almost_full = 1'b1;
    tick(2);
    snap = got_q.size();
    for (int k = 1; k < 10; k++) begin
      send(vecs[k].l, vecs[k].r);
      tick(9);
    end
    tick(8);
    chk("bp_no_bytes_while_full", got_q.size(), snap);
    tx_almost_full = 1'b0;
    tick(60);
    push_hdr(16'h0002);
    for (int k = 0; k < 10; k++) push_word(vecs[k].exp_word);
    chk_stream("bp_stream_resumes");
    chk("bp_drop_cnt", {16'd0, drop_cnt}, 32'd0);
    chk("bp_overflow", {31'd0, overflow}, 32'd0);

    // Overflow: 20 samples into a 16-deep FIFO with no pops.
    clear_q();
    tx_almost_full = 1'b1;
    tick(2);
    for (int k = 0; k < 20; k++) send(16'h0100 + 16'(k), 16'h0200 + 16'(k));
    tick(2);
    chk("ovf_drop_cnt", {16'd0, drop_cnt}, 32'd4);
    chk("ovf_overflow", {31'd0, overflow}, 32'd1);
    chk("ovf_no_bytes_while_full", got_q.size(), 0);
    tx_almost_full = 1'b0;
    tick(100);
    for (int k = 0; k < 16; k++) push_word({16'h0100 + 16'(k), 16'h0200 + 16'(k)});
    chk_stream("ovf_first16_in_order");

    // Reset in the middle of a sample.
    send(16'h1111, 16'h2222);
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("midrst_wr_en", {31'd0, tx_wr_en}, 32'd0);
    chk("midrst_pkt_seq", {16'd0, pkt_seq}, 32'd0);
    chk("midrst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
    chk("midrst_overflow", {31'd0, overflow}, 32'd0);
    clear_q();
    send(16'h3333, 16'h4444);
    tick(20);
    push_hdr(16'h0000);
    push_word(32'h33334444);
    chk_stream("midrst_new_packet");

    // Sequence wrap from 16'hFFFF.
    do_reset();
    force dut.pkt_seq_q = 16'hFFFF;
    tick(1);
    release dut.pkt_seq_q;
    tick(1);
    chk("wrap_preload", {16'd0, pkt_seq}, 32'hFFFF);
    clear_q();
    send_ramp510();
    exp_ramp510(16'hFFFF);
    chk_stream("wrap_two_pkts");
    chk("wrap_seq_after", {16'd0, pkt_seq}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
